jtkicker_objscan: RTL and testbench

JTKICKER_OBJSCAN -- requirements
Module: jtkicker_objscan

---
 rtl/jtkicker_objscan.sv | 165 ++++++++++++++++
 tb/tb_jtkicker_objscan.sv | 347 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtkicker_objscan.sv
// Object table scanner: two CPU-visible 1 KiB banks and a per-line hit search that feeds the draw stage.
// Define JTKICKER_OBJ_LIMIT_EN to cap every line at 24 draw requests.
module jtkicker_objscan (
   input  logic       clk,
   input  logic       rst,
   input  logic       cpu_cen,
   input  logic [9:0] addr,
   input  logic [7:0] cpu_dout,
   input  logic       cpu_rnw,
   input  logic       obj1_cs,
   input  logic       obj2_cs,
   output logic [7:0] obj_dout,
   input  logic       hs,
   input  logic [7:0] vrender,
   input  logic       flip,
   output logic       dr_start,
   input  logic       dr_busy,
   output logic [8:0] dr_code,
   output logic [3:0] dr_pal,
   output logic       dr_hflip,
   output logic [7:0] dr_xpos,
   output logic [3:0] dr_ysub,
   output logic       done
);

   typedef enum logic [2:0] {IDLE, ADDR, LATCH, CHECK, WAIT} state_t;

   // Each bank is split into even/odd halves so one scanner read returns both bytes of an entry.
   logic [7:0] b1_even [0:511];
   logic [7:0] b1_odd  [0:511];
   logic [7:0] b2_even [0:511];
   logic [7:0] b2_odd  [0:511];

   logic [8:0] cpu_wa;
   logic       cpu_we;
   logic [7:0] cpu_rd1_q, cpu_rd2_q;
   logic [1:0] cpu_sel_q;

   state_t     st_q;
   logic [5:0] idx_q;
   logic       done_q;
   logic [8:0] scan_a;
   logic [6:0] s_attr;
   logic [7:0] s_code, s_x, s_y;
   logic [6:0] attr_q;
   logic [7:0] code_q, x_q, y_q;
   logic [8:0] dr_code_q;
   logic [3:0] dr_pal_q, dr_ysub_q;
   logic       dr_hflip_q;
   logic [7:0] dr_xpos_q;
   logic [7:0] ydiff;
   logic       hit;
   logic       limit_hit;

   assign cpu_wa = addr[9:1];
   assign cpu_we = cpu_cen & ~cpu_rnw;
   assign scan_a = {3'b000, idx_q};

   always_ff @(posedge clk) begin
      if (obj1_cs && cpu_we && !addr[0]) b1_even[cpu_wa] <= cpu_dout;
      if (obj1_cs && cpu_we &&  addr[0]) b1_odd[cpu_wa]  <= cpu_dout;
      if (obj2_cs && cpu_we && !addr[0]) b2_even[cpu_wa] <= cpu_dout;
      if (obj2_cs && cpu_we &&  addr[0]) b2_odd[cpu_wa]  <= cpu_dout;
      cpu_rd1_q <= addr[0] ? b1_odd[cpu_wa] : b1_even[cpu_wa];
      cpu_rd2_q <= addr[0] ? b2_odd[cpu_wa] : b2_even[cpu_wa];
      s_attr    <= b1_even[scan_a][6:0];
      s_code    <= b1_odd[scan_a];
      s_x       <= b2_even[scan_a];
      s_y       <= b2_odd[scan_a];
   end

   // Select is kept apart from the raw RAM data so reset can force 8'hFF without touching the RAM.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) cpu_sel_q <= 2'b00;
      else     cpu_sel_q <= {obj2_cs, obj1_cs};
   end

   assign obj_dout = cpu_sel_q[0] ? cpu_rd1_q :
                     cpu_sel_q[1] ? cpu_rd2_q : 8'hFF;

   assign ydiff    = (vrender ^ {8{flip}}) - y_q;
   assign hit      = (ydiff[7:4] == 4'd0);
   assign dr_start = (st_q == WAIT) && !dr_busy && !hs;

`ifdef JTKICKER_OBJ_LIMIT_EN
   logic [4:0] cnt_q;
   always_ff @(posedge clk or posedge rst) begin
      if (rst)           cnt_q <= 5'd0;
      else if (hs)       cnt_q <= 5'd0;
      else if (dr_start) cnt_q <= cnt_q + 5'd1;
   end
   assign limit_hit = (cnt_q == 5'd23);
`else
   assign limit_hit = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st_q       <= IDLE;
         idx_q      <= 6'd63;
         done_q     <= 1'b0;
         attr_q     <= 7'd0;
         code_q     <= 8'd0;
         x_q        <= 8'd0;
         y_q        <= 8'd0;
         dr_code_q  <= 9'd0;
         dr_pal_q   <= 4'd0;
         dr_hflip_q <= 1'b0;
         dr_xpos_q  <= 8'd0;
         dr_ysub_q  <= 4'd0;
      end else if (hs) begin
         st_q   <= ADDR;
         idx_q  <= 6'd63;
         done_q <= 1'b0;
      end else begin
         case (st_q)
            IDLE:  st_q <= IDLE;
            ADDR:  st_q <= LATCH;
            LATCH: begin
               attr_q <= s_attr;
               code_q <= s_code;
               x_q    <= s_x;
               y_q    <= s_y;
               st_q   <= CHECK;
            end
            CHECK: begin
               if (hit) begin
                  dr_code_q  <= {attr_q[6], code_q};
                  dr_pal_q   <= attr_q[3:0];
                  dr_hflip_q <= attr_q[4] ^ flip;
                  dr_xpos_q  <= x_q ^ {8{flip}};
                  dr_ysub_q  <= ydiff[3:0] ^ {4{attr_q[5]}};
                  st_q       <= WAIT;
               end else if (idx_q == 6'd0) begin
                  st_q   <= IDLE;
                  done_q <= 1'b1;
               end else begin
                  idx_q <= idx_q - 6'd1;
                  st_q  <= ADDR;
               end
            end
            WAIT: begin
               if (!dr_busy) begin
                  if (limit_hit || idx_q == 6'd0) begin
                     st_q   <= IDLE;
                     done_q <= 1'b1;
                  end else begin
                     idx_q <= idx_q - 6'd1;
                     st_q  <= ADDR;
                  end
               end
            end
            default: st_q <= IDLE;
         endcase
      end
   end

   assign dr_code  = dr_code_q;
   assign dr_pal   = dr_pal_q;
   assign dr_hflip = dr_hflip_q;
   assign dr_xpos  = dr_xpos_q;
   assign dr_ysub  = dr_ysub_q;
   assign done     = done_q;

endmodule

// File: tb/tb_jtkicker_objscan.sv
// Scoreboard bench for jtkicker_objscan: expected draws are queued with the table setup and matched on dr_start.
module tb_jtkicker_objscan;

   logic       clk = 1'b0, rst = 1'b1;
   logic       cpu_cen = 1'b0, cpu_rnw = 1'b1, obj1_cs = 1'b0, obj2_cs = 1'b0;
   logic [9:0] addr = 10'd0;
   logic [7:0] cpu_dout = 8'd0, obj_dout;
   logic       hs = 1'b0, flip = 1'b0, dr_busy = 1'b0;
   logic [7:0] vrender = 8'd0;
   logic       dr_start, dr_hflip, done;
   logic [8:0] dr_code;
   logic [3:0] dr_pal, dr_ysub;
   logic [7:0] dr_xpos;

   typedef struct packed {
      logic [8:0] code;
      logic [3:0] pal;
      logic       hflip;
      logic [7:0] xpos;
      logic [3:0] ysub;
   } draw_t;

   draw_t exp_q[$];
   draw_t got_q[$];
   int    got_cyc[$];
   int    n_chk = 0, n_fail = 0;
   int    done_cyc;
   bit    timed_out;

   always #5 clk = ~clk;

   jtkicker_objscan dut (
      .clk(clk), .rst(rst), .cpu_cen(cpu_cen), .addr(addr), .cpu_dout(cpu_dout),
      .cpu_rnw(cpu_rnw), .obj1_cs(obj1_cs), .obj2_cs(obj2_cs), .obj_dout(obj_dout),
      .hs(hs), .vrender(vrender), .flip(flip), .dr_start(dr_start), .dr_busy(dr_busy),
      .dr_code(dr_code), .dr_pal(dr_pal), .dr_hflip(dr_hflip), .dr_xpos(dr_xpos),
      .dr_ysub(dr_ysub), .done(done)
   );

   task automatic cpu_wr(input int bank, input logic [9:0] a, input logic [7:0] d);
      @(posedge clk); #1;
      obj1_cs = (bank == 1); obj2_cs = (bank == 2);
      addr = a; cpu_dout = d; cpu_rnw = 1'b0; cpu_cen = 1'b1;
   endtask

   task automatic cpu_idle();
      @(posedge clk); #1;
      obj1_cs = 1'b0; obj2_cs = 1'b0; cpu_rnw = 1'b1; cpu_cen = 1'b0;
   endtask

   task automatic set_entry(input int n, input logic [7:0] attr, input logic [7:0] code,
                            input logic [7:0] x, input logic [7:0] y);
      cpu_wr(1, 10'(2*n), attr);
      cpu_wr(1, 10'(2*n+1), code);
      cpu_wr(2, 10'(2*n), x);
      cpu_wr(2, 10'(2*n+1), y);
   endtask

   task automatic fill_table();
      for (int n = 0; n < 64; n++) set_entry(n, 8'h00, 8'h00, 8'h00, 8'hF0);
   endtask

   // Pulses hs in cycle 0, models the downstream busy flag and records every dr_start until done or max_cyc.
   task automatic run_scan(input int busy_len, input int max_cyc);
      int    busy_left;
      draw_t d;
      got_q.delete(); got_cyc.delete();
      done_cyc = -1; timed_out = 1'b0; busy_left = 0;
      for (int c = 0; c < max_cyc; c++) begin
         @(posedge clk); #1;
         hs = (c == 0);
         dr_busy = (busy_left > 0);
         if (busy_left > 0) busy_left--;
         @(negedge clk);
         if (dr_start) begin
            d = {dr_code, dr_pal, dr_hflip, dr_xpos, dr_ysub};
            got_q.push_back(d);
            got_cyc.push_back(c);
            busy_left = busy_len;
         end
         if (c > 0 && done) begin
            done_cyc = c;
            break;
         end
      end
      if (done_cyc < 0) timed_out = 1'b1;
   endtask

   task automatic test_reset();
      int done_seen;
      #1;
      n_chk++;
      if ({dr_start, done, obj_dout} !== {1'b0, 1'b0, 8'hFF}) begin
         n_fail++; $display("FAIL reset_ctl: start/done/dout=%b/%b/%h want 0/0/ff", dr_start, done, obj_dout);
      end
      n_chk++;
      if ({dr_code, dr_pal, dr_hflip, dr_xpos, dr_ysub} !== 26'd0) begin
         n_fail++; $display("FAIL reset_dr: code=%h pal=%h hf=%b x=%h ys=%h want all 0", dr_code, dr_pal, dr_hflip, dr_xpos, dr_ysub);
      end
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      done_seen = 0;
      repeat (20) begin
         @(negedge clk);
         if (done) done_seen++;
      end
      n_chk++;
      if (done_seen !== 0) begin
         n_fail++; $display("FAIL reset_done_before_hs: done high %0d cycles, want 0", done_seen);
      end
   endtask

   task automatic test_cpu();
      cpu_wr(1, 10'h07E, 8'h5A);
      cpu_wr(2, 10'h07E, 8'hA5);
      cpu_idle();
      @(posedge clk); #1;
      obj1_cs = 1'b1; addr = 10'h07E; cpu_rnw = 1'b1; cpu_cen = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (obj_dout !== 8'h5A) begin
         n_fail++; $display("FAIL cpu_read_bank1: got %h want 5a", obj_dout);
      end
      obj1_cs = 1'b0; obj2_cs = 1'b1;
      @(posedge clk); #1;
      n_chk++;
      if (obj_dout !== 8'hA5) begin
         n_fail++; $display("FAIL cpu_read_bank2: got %h want a5", obj_dout);
      end
      obj2_cs = 1'b0;
      @(posedge clk); #1;
      n_chk++;
      if (obj_dout !== 8'hFF) begin
         n_fail++; $display("FAIL cpu_read_none: got %h want ff", obj_dout);
      end
   endtask

   task automatic test_nohit();
      fill_table(); cpu_idle();
      vrender = 8'h45; flip = 1'b0;
      run_scan(0, 400);
      n_chk++;
      if (got_q.size() !== 0) begin
         n_fail++; $display("FAIL nohit_count: got %0d draws want 0", got_q.size());
      end
      n_chk++;
      if (timed_out || done_cyc > 193) begin
         n_fail++; $display("FAIL nohit_time: done at cycle %0d (timeout=%0d) want <= 193", done_cyc, timed_out);
      end
   endtask

   task automatic test_single_hit();
      draw_t e, g;
      fill_table();
      set_entry(5, 8'h43, 8'h12, 8'h20, 8'h40);
      cpu_idle();
      exp_q.push_back({9'h112, 4'h3, 1'b0, 8'h20, 4'h5});
      vrender = 8'h45; flip = 1'b0;
      run_scan(0, 400);
      n_chk++;
      if (got_q.size() !== 1 || timed_out) begin
         n_fail++; $display("FAIL single_count: got %0d draws timeout=%0d want 1/0", got_q.size(), timed_out);
      end
      n_chk++;
      if (got_cyc.size() == 0 || got_cyc[0] !== 178) begin
         n_fail++; $display("FAIL single_cycle: first dr_start cycle %0d want 178", got_cyc.size() ? got_cyc[0] : -1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.size() ? got_q.pop_front() : '0;
         n_chk++;
         if (g !== e) begin
            n_fail++; $display("FAIL single_draw: got %h want %h", g, e);
         end
      end
   endtask

   task automatic test_wrap_flip();
      draw_t e, g;
      fill_table();
      set_entry(40, 8'h3A, 8'h01, 8'h10, 8'hFA);
      set_entry(20, 8'h15, 8'h9C, 8'h37, 8'hF8);
      cpu_idle();
      for (int f = 0; f < 2; f++) begin
         if (f == 0) begin
            vrender = 8'h03; flip = 1'b0;
            exp_q.push_back({9'h001, 4'hA, 1'b1, 8'h10, 4'h6});
            exp_q.push_back({9'h09C, 4'h5, 1'b1, 8'h37, 4'hB});
         end else begin
            vrender = 8'hFC; flip = 1'b1;
            exp_q.push_back({9'h001, 4'hA, 1'b0, 8'hEF, 4'h6});
            exp_q.push_back({9'h09C, 4'h5, 1'b0, 8'hC8, 4'hB});
         end
         run_scan(0, 400);
         n_chk++;
         if (got_q.size() !== 2 || timed_out) begin
            n_fail++; $display("FAIL wrap_count flip=%0d: got %0d draws timeout=%0d want 2/0", f, got_q.size(), timed_out);
         end
         while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() ? got_q.pop_front() : '0;
            n_chk++;
            if (g !== e) begin
               n_fail++; $display("FAIL wrap_draw flip=%0d: got %h want %h", f, g, e);
            end
         end
      end
      flip = 1'b0;
   endtask

   task automatic load_pair();
      fill_table();
      set_entry(10, 8'h01, 8'hAA, 8'h11, 8'h40);
      set_entry(3, 8'h02, 8'hBB, 8'h22, 8'h40);
      cpu_idle();
      vrender = 8'h45; flip = 1'b0;
   endtask

   task automatic test_handshake();
      draw_t e, g;
      load_pair();
      exp_q.push_back({9'h0AA, 4'h1, 1'b0, 8'h11, 4'h5});
      exp_q.push_back({9'h0BB, 4'h2, 1'b0, 8'h22, 4'h5});
      run_scan(50, 600);
      n_chk++;
      if (got_q.size() !== 2 || timed_out) begin
         n_fail++; $display("FAIL hs_count: got %0d draws timeout=%0d want 2/0", got_q.size(), timed_out);
      end else begin
         n_chk++;
         if (got_cyc[0] !== 163 || got_cyc[1] - got_cyc[0] !== 51) begin
            n_fail++; $display("FAIL hs_timing: cycles %0d,%0d want 163,214", got_cyc[0], got_cyc[1]);
         end
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.size() ? got_q.pop_front() : '0;
         n_chk++;
         if (g !== e) begin
            n_fail++; $display("FAIL hs_draw: got %h want %h", g, e);
         end
      end
   endtask

   task automatic test_restart();
      draw_t e, g;
      run_scan(1000, 300);
      n_chk++;
      if (got_q.size() !== 1 || !timed_out || done) begin
         n_fail++; $display("FAIL restart_setup: draws=%0d timeout=%0d done=%b want 1/1/0", got_q.size(), timed_out, done);
      end
      exp_q.push_back({9'h0AA, 4'h1, 1'b0, 8'h11, 4'h5});
      exp_q.push_back({9'h0BB, 4'h2, 1'b0, 8'h22, 4'h5});
      run_scan(0, 600);
      n_chk++;
      if (got_q.size() !== 2 || got_cyc[0] !== 163) begin
         n_fail++; $display("FAIL restart_seq: draws=%0d first cycle %0d want 2 at 163", got_q.size(), got_cyc.size() ? got_cyc[0] : -1);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.size() ? got_q.pop_front() : '0;
         n_chk++;
         if (g !== e) begin
            n_fail++; $display("FAIL restart_draw: got %h want %h", g, e);
         end
      end
   endtask

   task automatic test_rst_mid();
      int starts, dones;
      draw_t e, g;
      run_scan(0, 170);
      @(posedge clk); #1 rst = 1'b1;
      #1;
      n_chk++;
      if ({dr_start, done, obj_dout, dr_code, dr_pal, dr_hflip, dr_xpos, dr_ysub} !== {2'b00, 8'hFF, 26'd0}) begin
         n_fail++; $display("FAIL rst_mid_outputs: start=%b done=%b dout=%h code=%h pal=%h x=%h ys=%h", dr_start, done, obj_dout, dr_code, dr_pal, dr_xpos, dr_ysub);
      end
      @(posedge clk); #1 rst = 1'b0;
      starts = 0; dones = 0;
      repeat (300) begin
         @(negedge clk);
         if (dr_start) starts++;
         if (done) dones++;
      end
      n_chk++;
      if (starts !== 0 || dones !== 0) begin
         n_fail++; $display("FAIL rst_mid_quiet: starts=%0d done_cycles=%0d want 0/0", starts, dones);
      end
      exp_q.push_back({9'h0AA, 4'h1, 1'b0, 8'h11, 4'h5});
      exp_q.push_back({9'h0BB, 4'h2, 1'b0, 8'h22, 4'h5});
      run_scan(0, 600);
      n_chk++;
      if (got_q.size() !== 2 || timed_out) begin
         n_fail++; $display("FAIL rst_mid_rescan: draws=%0d timeout=%0d want 2/0", got_q.size(), timed_out);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.size() ? got_q.pop_front() : '0;
         n_chk++;
         if (g !== e) begin
            n_fail++; $display("FAIL rst_mid_draw: got %h want %h", g, e);
         end
      end
   endtask

   task automatic test_limit();
      int    lim;
      draw_t e, g;
`ifdef JTKICKER_OBJ_LIMIT_EN
      lim = 24;
`else
      lim = 64;
`endif
      for (int n = 0; n < 64; n++) set_entry(n, 8'h00, 8'(n), 8'(n), 8'h40);
      cpu_idle();
      vrender = 8'h40; flip = 1'b0;
      for (int n = 63; n > 63 - lim; n--) exp_q.push_back({9'(n), 4'h0, 1'b0, 8'(n), 4'h0});
      run_scan(0, 2000);
      n_chk++;
      if (got_q.size() !== lim || timed_out || !done) begin
         n_fail++; $display("FAIL limit_count: draws=%0d timeout=%0d done=%b want %0d/0/1", got_q.size(), timed_out, done, lim);
      end
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         g = got_q.size() ? got_q.pop_front() : '0;
         n_chk++;
         if (g !== e) begin
            n_fail++; $display("FAIL limit_draw: got %h want %h", g, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_cpu();
      test_nohit();
      test_single_hit();
      test_wrap_flip();
      test_handshake();
      test_restart();
      test_rst_mid();
      test_limit();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
